// File: rtl/div_mon_pkg.sv
// Shared types and default sizing for the divided-clock monitor.
package div_mon_pkg;

  localparam int unsigned CntWDefault      = 8;
  localparam int unsigned LockCountDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StMeasure
  } state_t;

endpackage

// File: rtl/div_clk_monitor_if.sv
// Control and measurement bundle between a divided-clock monitor and its user.
interface div_clk_monitor_if
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) ();

  logic             div_clk;
  logic             enable;
  logic [CNT_W-1:0] exp_period;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err;

  modport master (
    output div_clk, enable, exp_period, err_clr,
    input  period, high_time, meas_valid, locked, err
  );

  modport slave (
    input  div_clk, enable, exp_period, err_clr,
    output period, high_time, meas_valid, locked, err
  );

endinterface

// File: rtl/div_clk_edge_det.sv
// Registers div_clk (sampled as data on clk) and flags its 0->1 transitions.
module div_clk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic div_clk,
  output logic rise
);

  logic div_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_clk;
    end
  end

  assign rise = div_clk & ~div_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period/high time of a divided clock in clk cycles and reports lock and sticky error.
// Define DIV_MON_DUTY_CHECK_EN to also flag div_clk duty cycles more than one sample off 50%.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = CntWDefault,
  parameter int unsigned LOCK_COUNT = LockCountDefault
) (
  input logic              clk,
  input logic              rst,
  div_clk_monitor_if.slave mon
);

  localparam int unsigned            MatchW   = $clog2(LOCK_COUNT + 1);
  localparam logic [MatchW-1:0]      MatchMax = MatchW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]       CntMax   = '1;
  localparam logic [CNT_W-1:0]       CntOne   = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    hcnt_q, hcnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    high_q, high_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [MatchW-1:0]   match_inc;
  logic                rise;
  logic                duty_bad;
  logic                err_set;

  div_clk_edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .div_clk (mon.div_clk),
    .rise    (rise)
  );

`ifdef DIV_MON_DUTY_CHECK_EN
  logic [CNT_W:0] hi_x, lo_x;
  assign hi_x     = {1'b0, hcnt_q};
  assign lo_x     = {1'b0, cnt_q - hcnt_q};
  assign duty_bad = (hi_x > lo_x + 1'b1) || (lo_x > hi_x + 1'b1);
`else
  assign duty_bad = 1'b0;
`endif

  assign match_inc = (match_q == MatchMax) ? match_q : match_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    match_d  = match_q;
    err_set  = 1'b0;

    if (!mon.enable) begin
      state_d  = StIdle;
      cnt_d    = '0;
      hcnt_d   = '0;
      locked_d = 1'b0;
      match_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSync;
        StSync: begin
          if (rise) begin
            cnt_d   = CntOne;
            hcnt_d  = CntOne;
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            cnt_d    = CntOne;
            hcnt_d   = CntOne;
            if (cnt_q == mon.exp_period && !duty_bad) begin
              match_d  = match_inc;
              locked_d = (match_inc == MatchMax);
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
              err_set  = 1'b1;
            end
          end else if (cnt_q == CntMax) begin
            // No edge within the counter range: drop lock and resynchronise.
            err_set  = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            cnt_d    = '0;
            hcnt_d   = '0;
            state_d  = StSync;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            hcnt_d = hcnt_q + CNT_W'(mon.div_clk);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A new error outranks a simultaneous clear.
    err_d = err_q;
    if (mon.err_clr) err_d = 1'b0;
    if (err_set)     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      match_q  <= match_d;
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_q;
  assign mon.meas_valid = valid_q;
  assign mon.locked     = locked_q;
  assign mon.err        = err_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench for div_clk_monitor: directed div_clk patterns, expected measurements queued.
module tb_div_clk_monitor;
  import div_mon_pkg::*;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic          locked;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  div_clk_monitor_if #(.CNT_W(CW)) mon_if ();

  div_clk_monitor #(
    .CNT_W      (CW),
    .LOCK_COUNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic sample(input logic v, input logic clr = 1'b0);
    mon_if.div_clk = v;
    mon_if.err_clr = clr;
    @(posedge clk);
    #1;
    mon_if.err_clr = 1'b0;
  endtask

  task automatic cyc(input int hi, input int lo);
    for (int i = 0; i < hi; i++) sample(1'b1);
    for (int i = 0; i < lo; i++) sample(1'b0);
  endtask

  task automatic push(input int p, input int h, input bit l, input bit e);
    exp_t x;
    x.period = CW'(p);
    x.high   = CW'(h);
    x.locked = l;
    x.err    = e;
    sb_q.push_back(x);
  endtask

  // Monitor: every meas_valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (mon_if.meas_valid === 1'b1) begin
        checks++;
        a = {mon_if.period, mon_if.high_time, mon_if.locked, mon_if.err};
        if (sb_q.size() == 0) begin
          $display("FAIL meas_unexpected: got period=%0d high=%0d locked=%0d err=%0d, expected none",
                   a.period, a.high, a.locked, a.err);
        end else begin
          e = sb_q.pop_front();
          if (a === e) passed++;
          else $display("FAIL meas: got p=%0d h=%0d l=%0d e=%0d, expected p=%0d h=%0d l=%0d e=%0d",
                        a.period, a.high, a.locked, a.err, e.period, e.high, e.locked, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    mon_if.div_clk    = 1'b0;
    mon_if.enable     = 1'b0;
    mon_if.err_clr    = 1'b0;
    mon_if.exp_period = CW'(3);
    rst = 1'b0;
    sample(1'b0);
    sample(1'b0);
    check("rst_period", int'(mon_if.period), 0);
    check("rst_high", int'(mon_if.high_time), 0);
    check("rst_valid", int'(mon_if.meas_valid), 0);
    check("rst_locked", int'(mon_if.locked), 0);
    check("rst_err", int'(mon_if.err), 0);
    check("rst_state", int'(dut.state_q), int'(StIdle));

    // Ideal divide-by-3, lock after the 5th edge.
    rst = 1'b1;
    mon_if.enable = 1'b1;
    sample(1'b0);
    check("state_sync", int'(dut.state_q), int'(StSync));
    cyc(2, 1);
    for (int k = 0; k < 5; k++) begin
      push(3, 2, k >= 3, 1'b0);
      cyc(2, 1);
    end

    // One long period, then relock with err held.
    push(3, 2, 1'b1, 1'b0);
    cyc(2, 2);
    push(4, 2, 1'b0, 1'b1);
    cyc(2, 1);
    for (int k = 0; k < 4; k++) begin
      push(3, 2, k == 3, 1'b1);
      cyc(2, 1);
    end
    push(3, 2, 1'b1, 1'b0);
    sample(1'b1, 1'b1);
    cyc(1, 1);

    // err_clr coincident with a mismatching edge: set wins.
    sample(1'b0);
    push(4, 2, 1'b0, 1'b1);
    sample(1'b1, 1'b1);
    cyc(1, 1);
    for (int k = 0; k < 3; k++) begin
      push(3, 2, 1'b0, 1'b1);
      cyc(2, 1);
    end
    push(3, 2, 1'b1, 1'b0);
    sample(1'b1, 1'b1);
    sample(1'b1);

    // Timeout: cnt climbs to 15, next idle sample fires.
    for (int k = 0; k < 13; k++) sample(1'b0);
    check("pre_to_err", int'(mon_if.err), 0);
    check("pre_to_state", int'(dut.state_q), int'(StMeasure));
    sample(1'b0);
    check("to_err", int'(mon_if.err), 1);
    check("to_locked", int'(mon_if.locked), 0);
    check("to_state", int'(dut.state_q), int'(StSync));
    check("to_period", int'(mon_if.period), 3);
    check("to_high", int'(mon_if.high_time), 2);

    // Relock, then drop enable mid-period.
    cyc(2, 1);
    for (int k = 0; k < 4; k++) begin
      push(3, 2, k == 3, 1'b1);
      cyc(2, 1);
    end
    check("pre_en_locked", int'(mon_if.locked), 1);
    mon_if.enable = 1'b0;
    sample(1'b0);
    check("en_state", int'(dut.state_q), int'(StIdle));
    check("en_locked", int'(mon_if.locked), 0);
    check("en_period", int'(mon_if.period), 3);
    check("en_err", int'(mon_if.err), 1);

    // Reset pulse during MEASURE clears everything.
    mon_if.enable = 1'b1;
    sample(1'b0);
    cyc(2, 1);
    push(3, 2, 1'b0, 1'b1);
    cyc(2, 1);
    rst = 1'b0;
    sample(1'b1);
    rst = 1'b1;
    check("mrst_period", int'(mon_if.period), 0);
    check("mrst_high", int'(mon_if.high_time), 0);
    check("mrst_valid", int'(mon_if.meas_valid), 0);
    check("mrst_locked", int'(mon_if.locked), 0);
    check("mrst_err", int'(mon_if.err), 0);
    check("mrst_state", int'(dut.state_q), int'(StIdle));

    // 25% duty divide-by-4.
    mon_if.enable = 1'b0;
    mon_if.exp_period = CW'(4);
    sample(1'b0);
    mon_if.enable = 1'b1;
    sample(1'b0);
    cyc(1, 3);
    for (int k = 0; k < 4; k++) begin
`ifdef DIV_MON_DUTY_CHECK_EN
      push(4, 1, 1'b0, 1'b1);
`else
      push(4, 1, k == 3, 1'b0);
`endif
      cyc(1, 3);
    end

    sample(1'b0);
    sample(1'b0);
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

- Checks a divided clock such as a divide-by-3 output against the system clock it was derived from.
- Measures the period and high time of every cycle of `div_clk`, counted in `clk` cycles.
- Compares the period with a programmed expected ratio and reports lock and a sticky error.
- Sits next to each clock divider as a built-in self-check.

## Interface
Parameters:
- `CNT_W`, 8: width of the period and high-time counters and outputs.
- `LOCK_COUNT`, 4: number of consecutive matching periods required before `locked` asserts.

Ports:
- `clk` in 1: system clock, the source clock of `div_clk`. All logic is on its posedge.
- `rst` in 1: reset, synchronous, active-low.
- `div_clk` in 1: divided clock under test. It is sampled as data and is treated as synchronous to `clk`; there is no synchronizer.
- `enable` in 1: 0 holds the block in IDLE.
- `exp_period` in CNT_W: expected period in `clk` cycles, valid range 2 to 2^CNT_W−2. It must be stable while `enable`=1.
- `err_clr` in 1: one-cycle pulse that clears `err`.
- `period` out CNT_W: last measured period.
- `high_time` out CNT_W: number of `clk` samples with `div_clk`=1 in the last period.
- `meas_valid` out 1: one-cycle pulse when `period` and `high_time` update.
- `locked` out 1: asserted after LOCK_COUNT consecutive periods equal to `exp_period`.
- `err` out 1: sticky flag for a mismatch or a timeout.

## Operation
- Reset (`rst`=0): all outputs are 0 and the FSM is in IDLE.
- Rising edge detection: `div_q` is `div_clk` registered. `rise` = `div_clk` & ~`div_q`.
- FSM states:
  - IDLE: leave to SYNC when `enable`=1.
  - SYNC: wait for `rise`. On `rise`, set `cnt`=1 and `hcnt`=1, then go to MEASURE. The first edge produces no measurement.
  - MEASURE, cycles without `rise`:
    - `cnt` += 1.
    - `hcnt` += `div_clk`.
  - MEASURE, cycle with `rise`:
    - `period` <= `cnt` and `high_time` <= `hcnt`.
    - `meas_valid` pulses.
    - Reload `cnt`=1 and `hcnt`=1.
    - Run the match check (below).
- Match check:
  - `period` == `exp_period`: `match_cnt` increments, saturating at LOCK_COUNT. `locked`=1 once `match_cnt` reaches LOCK_COUNT.
  - Otherwise: `match_cnt`=0, `locked`=0, `err`=1.
- Timeout: `cnt` reaches all-ones with no `rise`. Then `err`=1, `locked`=0, `match_cnt`=0, and the FSM returns to SYNC. There is no `meas_valid` and `period` is not updated.
- `enable` deasserted in any state: next state is IDLE. `locked`, `match_cnt`, `cnt` and `hcnt` clear. `period`, `high_time` and `err` hold.
- `err_clr`: clears `err`. If an error event occurs in the same cycle, `err` stays 1 (set wins).
- Counter widths: `cnt` and `hcnt` are CNT_W bits and never wrap; the timeout fires first.

## Timing
- `meas_valid`, `period`, `high_time`, `locked` and `err` are registered and update on the clock edge after the `rise` sample.
- Latency from a `div_clk` 0→1 transition at the sampling edge to `meas_valid`: 1 `clk` cycle.
- Time to `locked`: LOCK_COUNT+1 rising edges after `enable` (one sync edge plus LOCK_COUNT measured edges).
- Reset in mid-operation takes priority over every other input.

## Configuration
- `DIV_MON_DUTY_CHECK_EN` defined:
  - On each `rise` in MEASURE, low time = `period` − `high_time`.
  - If |`high_time` − low time| > 1, then `err`=1 and `locked`=0 in the same update.
  - This means `div_clk` must be within one sample of 50% duty.
- Macro undefined: duty is not checked and `high_time` is report-only.

## Structure
- Package `div_mon_pkg`:
  - `state_t` enum: IDLE, SYNC, MEASURE.
  - Default localparams for CNT_W and LOCK_COUNT.
- Sub-module `div_clk_edge_det`: the `div_q` register and `rise` output, with a synchronous active-low reset on `rst`.
- Top level contains the FSM, counters, compare logic and status registers.

## Test plan
- Ideal divide-by-3 (`div_clk` = 1,1,0 repeating), `exp_period`=3, LOCK_COUNT=4:
  - `meas_valid` pulses every 3 cycles from the 2nd edge on, with `period`=3 and `high_time`=2.
  - `locked`=1 after the 5th edge; `err`=0.
- Locked stream, then one period of 4:
  - The next measurement gives `period`=4, `locked`=0, `err`=1.
  - After 4 more good periods `locked`=1 again and `err` stays 1 until `err_clr`.
- `div_clk` held at 0 after lock with CNT_W=4:
  - Timeout at `cnt`=15 gives `err`=1, `locked`=0 and the FSM in SYNC.
  - `period` keeps its old value of 3.
- `enable` dropped in mid-MEASURE, and `rst`=0 asserted for one cycle during MEASURE:
  - `enable` dropped: state goes to IDLE and `locked` clears, while `period` holds.
  - `rst`=0: every output reads 0 on the next cycle.
- `err_clr` pulsed in the same cycle as a mismatching edge: `err` stays 1.
- With `DIV_MON_DUTY_CHECK_EN` defined, `div_clk` pattern 1,0,0,0 and `exp_period`=4:
  - `period`=4, `high_time`=1, `err`=1.
  - With the macro undefined the same stimulus reaches lock with no error.
